// File: rtl/modulo_updown_counter.sv
// Up/down modulo counter with programmable bound, wrap/saturate mode and a clock-enable prescaler.
// Step and terminal-count pulses are registered alongside the count.
module modulo_updown_counter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      ld,
  input  logic [WIDTH-1:0]          v,
  input  logic                      dir,
  input  logic                      sat,
  input  logic [WIDTH-1:0]          mod_max,
  input  logic [PRESCALE_WIDTH-1:0] div,
  output logic [WIDTH-1:0]          count,
  output logic                      step,
  output logic                      tc
);

  logic [WIDTH-1:0]          count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      step_q, step_d;
  logic                      tc_q, tc_d;
  logic                      step_event;

  // A prescaler left above a freshly reduced div counts as having reached it.
  assign step_event = en && (pre_q >= div);

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    step_d  = 1'b0;
    tc_d    = 1'b0;
    if (ld) begin
      count_d = (v > mod_max) ? mod_max : v;
      pre_d   = '0;
    end else if (en) begin
      if (step_event) begin
        pre_d  = '0;
        step_d = 1'b1;
        if (count_q > mod_max) begin
          count_d = mod_max;
        end else if (dir) begin
          if (count_q == mod_max) begin
            tc_d    = 1'b1;
            count_d = sat ? mod_max : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            tc_d    = 1'b1;
            count_d = sat ? '0 : mod_max;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end else begin
        pre_d = pre_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pre_q   <= '0;
      step_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign tc    = tc_q;

endmodule
